// File: rtl/riscv_v_exe_seq.sv
// Multi-cycle RVV integer execute unit: walks a register group one register per cycle,
// computing per-element ALU results and vstart/vl/v0 byte write-enables for the RF write port.

module riscv_v_exe_lane #(
    parameter int W = 8
) (
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);
    always_comb begin
        case (op)
            3'b000:  y = a + b;
            3'b001:  y = a - b;
            3'b010:  y = a & b;
            3'b011:  y = a | b;
            3'b100:  y = a ^ b;
            3'b101:  y = (a < b) ? a : b;
            3'b110:  y = ($signed(a) < $signed(b)) ? a : b;
            default: y = ($signed(a) > $signed(b)) ? a : b;
        endcase
    end
endmodule

module riscv_v_exe_seq #(
    parameter int VLEN     = 128,
    parameter int MAX_LMUL = 8,
    parameter int XLEN     = 32,
    localparam int VLENB   = VLEN / 8,
    localparam int VLW     = $clog2(VLENB * MAX_LMUL) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2:0]                op,
    input  logic [1:0]                sew,
    input  logic [2:0]                lmul,
    input  logic [VLW-1:0]            vl,
    input  logic [VLW-1:0]            vstart,
    input  logic                      vm,
    input  logic                      is_scalar,
    input  logic [XLEN-1:0]           scalar_data,
    input  logic [4:0]                vd_addr,
    input  logic [4:0]                vs1_addr,
    input  logic [4:0]                vs2_addr,
    input  logic [VLENB*MAX_LMUL-1:0] v0_mask,
    output logic [4:0]                rf_rd_addr_a,
    output logic [4:0]                rf_rd_addr_b,
    output logic                      rf_rd_en,
    input  logic [VLEN-1:0]           rf_rd_data_a,
    input  logic [VLEN-1:0]           rf_rd_data_b,
    output logic [VLENB-1:0]          rf_wr_en,
    output logic [4:0]                rf_wr_addr,
    output logic [VLEN-1:0]           rf_wr_data,
    output logic                      done,
    output logic                      err
);
    localparam int RW  = $clog2(MAX_LMUL) + 1;
    localparam int BIW = VLW - 1;
    localparam int LB  = $clog2(VLENB);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN1, DRAIN2} state_e;

    typedef struct packed {
        logic [2:0]      op;
        logic [1:0]      sew;
        logic [VLW-1:0]  vl;
        logic [VLW-1:0]  vstart;
        logic            vm;
        logic            is_scalar;
        logic [XLEN-1:0] sdata;
        logic [4:0]      vd;
        logic [4:0]      vs1;
        logic [4:0]      vs2;
        logic [RW-1:0]   nreg;
    } cfg_t;

    state_e                    state_q, state_d;
    cfg_t                      cfg_q, cfg_d;
    logic [VLENB*MAX_LMUL-1:0] v0_q, v0_d;
    logic [RW-1:0]             r_q, r_d;
    logic                      rd_vld_q, rd_vld_d;
    logic [RW-1:0]             rd_r_q, rd_r_d;
    logic                      rd_last_q, rd_last_d;
    logic [VLENB-1:0]          wr_en_q, wr_en_d;
    logic [4:0]                wr_addr_q, wr_addr_d;
    logic [VLEN-1:0]           wr_data_q, wr_data_d;
    logic                      done_q, done_d;
    logic                      err_q, err_d;

    logic                      accept, illegal, empty, last_r;
    int unsigned               lmul_n, need;
    logic [4:0]                amask;
    logic [RW-1:0]             nreg_in;
    logic [VLENB-1:0]          be;
    logic [BIW-1:0]            bidx, eidx;
    logic [3:0][VLEN-1:0]      res_sew;
    logic [VLEN-1:0]           res;
    logic signed [63:0]        scal64;

    // Legality and group length are judged on the live inputs at accept time.
    always_comb begin
        accept  = in_valid && (state_q == IDLE);
        lmul_n  = 32'd1 << lmul[1:0];
        amask   = 5'(lmul_n - 1);
        illegal = lmul[2] || (lmul_n > 32'(MAX_LMUL)) ||
                  (|(vd_addr & amask)) || (|(vs2_addr & amask)) ||
                  (!is_scalar && (|(vs1_addr & amask)));
        need    = ((32'(vl) << sew) + 32'(VLENB - 1)) >> LB;
        nreg_in = RW'((need < lmul_n) ? need : lmul_n);
        empty   = (vl == '0) || (vstart >= vl);
        last_r  = (r_q == cfg_q.nreg - RW'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && !illegal && !empty) state_d = RUN;
            RUN:     if (last_r) state_d = DRAIN1;
            DRAIN1:  state_d = DRAIN2;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready     = (state_q == IDLE);
        rf_rd_en     = (state_q == RUN);
        rf_rd_addr_a = cfg_q.vs2 + 5'(r_q);
        rf_rd_addr_b = cfg_q.vs1 + 5'(r_q);
    end

    assign scal64 = 64'($signed(cfg_q.sdata));

    for (genvar s = 0; s < 4; s++) begin : g_sew
        localparam int W = 8 << s;
        for (genvar e = 0; e < VLEN / W; e++) begin : g_lane
            logic [W-1:0] src1;
            assign src1 = cfg_q.is_scalar ? scal64[W-1:0] : rf_rd_data_b[e*W +: W];
            riscv_v_exe_lane #(.W(W)) u_lane (
                .op (cfg_q.op),
                .a  (rf_rd_data_a[e*W +: W]),
                .b  (src1),
                .y  (res_sew[s][e*W +: W])
            );
        end
    end

    assign res = res_sew[cfg_q.sew];

    // Byte b of register r belongs to element (r*VLENB + b) >> sew.
    always_comb begin
        be   = '0;
        bidx = '0;
        eidx = '0;
        for (int b = 0; b < VLENB; b++) begin
            bidx  = BIW'(rd_r_q) * BIW'(VLENB) + BIW'(b);
            eidx  = bidx >> cfg_q.sew;
            be[b] = (VLW'(eidx) >= cfg_q.vstart) && (VLW'(eidx) < cfg_q.vl) &&
                    (cfg_q.vm || v0_q[eidx]);
        end
    end

    always_comb begin
        cfg_d = cfg_q;
        v0_d  = v0_q;
        if (accept) begin
            cfg_d.op        = op;
            cfg_d.sew       = sew;
            cfg_d.vl        = vl;
            cfg_d.vstart    = vstart;
            cfg_d.vm        = vm;
            cfg_d.is_scalar = is_scalar;
            cfg_d.sdata     = scalar_data;
            cfg_d.vd        = vd_addr;
            cfg_d.vs1       = vs1_addr;
            cfg_d.vs2       = vs2_addr;
            cfg_d.nreg      = nreg_in;
            v0_d            = v0_mask;
        end
        r_d       = (state_q == RUN) ? r_q + RW'(1) : '0;
        rd_vld_d  = (state_q == RUN);
        rd_r_d    = r_q;
        rd_last_d = (state_q == RUN) && last_r;
        // Data/address hold between writes so idle outputs stay deterministic.
        wr_en_d   = rd_vld_q ? be : '0;
        wr_addr_d = rd_vld_q ? cfg_q.vd + 5'(rd_r_q) : wr_addr_q;
        wr_data_d = rd_vld_q ? res : wr_data_q;
        done_d    = (accept && !illegal && empty) || (rd_vld_q && rd_last_q);
        err_d     = accept && illegal;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_q     <= '0;
            v0_q      <= '0;
            r_q       <= '0;
            rd_vld_q  <= 1'b0;
            rd_r_q    <= '0;
            rd_last_q <= 1'b0;
            wr_en_q   <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            cfg_q     <= cfg_d;
            v0_q      <= v0_d;
            r_q       <= r_d;
            rd_vld_q  <= rd_vld_d;
            rd_r_q    <= rd_r_d;
            rd_last_q <= rd_last_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign rf_wr_en   = wr_en_q;
    assign rf_wr_addr = wr_addr_q;
    assign rf_wr_data = wr_data_q;
    assign done       = done_q;
    assign err        = err_q;
endmodule

// File: tb/tb_riscv_v_exe_seq.sv
// Bench for riscv_v_exe_seq: per-cycle expectation tables built from element-level arithmetic,
// checked every cycle, plus literal spot checks on the directed vectors.

module tb_riscv_v_exe_seq;
    localparam int VLEN  = 128;
    localparam int VLENB = 16;
    localparam int MAXL  = 8;
    localparam int XLEN  = 32;
    localparam int VLW   = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       op_i = '0;
    logic [1:0]       sew_i = '0;
    logic [2:0]       lmul_i = '0;
    logic [VLW-1:0]   vl_i = '0;
    logic [VLW-1:0]   vstart_i = '0;
    logic             vm_i = 1'b1;
    logic             iss_i = 1'b0;
    logic [XLEN-1:0]  scal_i = '0;
    logic [4:0]       vd_i = '0, vs1_i = '0, vs2_i = '0;
    logic [127:0]     v0_i = '0;
    logic [4:0]       rd_addr_a, rd_addr_b;
    logic             rf_rd_en;
    logic [VLEN-1:0]  rd_a = '0, rd_b = '0;
    logic [VLENB-1:0] rf_wr_en;
    logic [4:0]       rf_wr_addr;
    logic [VLEN-1:0]  rf_wr_data;
    logic             done, err;

    riscv_v_exe_seq #(.VLEN(VLEN), .MAX_LMUL(MAXL), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op_i), .sew(sew_i), .lmul(lmul_i), .vl(vl_i), .vstart(vstart_i),
        .vm(vm_i), .is_scalar(iss_i), .scalar_data(scal_i),
        .vd_addr(vd_i), .vs1_addr(vs1_i), .vs2_addr(vs2_i), .v0_mask(v0_i),
        .rf_rd_addr_a(rd_addr_a), .rf_rd_addr_b(rd_addr_b), .rf_rd_en(rf_rd_en),
        .rf_rd_data_a(rd_a), .rf_rd_data_b(rd_b),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [VLEN-1:0] rf [32];
    always @(posedge clk) begin
        if (rf_rd_en) begin
            rd_a <= rf[rd_addr_a];
            rd_b <= rf[rd_addr_b];
        end
    end

    int checks = 0;
    int fails  = 0;
    bit chk_en = 1'b0;
    int end_cyc = 0;

    logic [VLENB-1:0] e_wen   [int];
    logic [4:0]       e_waddr [int];
    logic [VLEN-1:0]  e_wdata [int];
    logic [9:0]       e_rd    [int];
    bit               e_done  [int];
    bit               e_err   [int];
    bit               e_busy  [int];

    task automatic chk(input string nm, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [63:0] elem(input int rg, input int e, input int w);
        logic [VLEN-1:0] t;
        t = rf[rg % 32] >> (e * w);
        return (w == 64) ? t[63:0] : (t[63:0] & ((64'd1 << w) - 64'd1));
    endfunction

    function automatic logic [63:0] alu(input int op, input logic [63:0] a, input logic [63:0] b, input int w);
        longint sa, sb;
        sa = longint'(a << (64 - w)) >>> (64 - w);
        sb = longint'(b << (64 - w)) >>> (64 - w);
        case (op)
            0: return a + b;
            1: return a - b;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return (a < b) ? a : b;
            6: return (sa < sb) ? a : b;
            default: return (sa > sb) ? a : b;
        endcase
    endfunction

    task automatic model(input int acc, input int op, input int sew, input logic [2:0] lmul,
                         input int vl, input int vstart, input bit vm, input bit iss,
                         input logic [31:0] scal, input int vd, input int vs1, input int vs2,
                         input logic [127:0] v0);
        int lm, sewb, w, epr, need, nreg, idx;
        logic [63:0] msk, a, b, sx;
        logic [VLEN-1:0] d;
        logic [VLENB-1:0] en;
        lm = 1 << lmul[1:0];
        if (lmul[2] || lm > MAXL || (vd % lm) != 0 || (vs2 % lm) != 0 || (!iss && (vs1 % lm) != 0)) begin
            e_err[acc] = 1'b1;
            end_cyc = acc;
            return;
        end
        if (vl == 0 || vstart >= vl) begin
            e_done[acc] = 1'b1;
            end_cyc = acc;
            return;
        end
        sewb = 1 << sew;
        w    = 8 * sewb;
        epr  = VLENB / sewb;
        need = (vl * sewb + VLENB - 1) / VLENB;
        nreg = (need < lm) ? need : lm;
        msk  = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        sx   = {{32{scal[31]}}, scal};
        for (int r = 0; r < nreg; r++) begin
            d  = '0;
            en = '0;
            for (int e = 0; e < epr; e++) begin
                idx = r * epr + e;
                a = elem(vs2 + r, e, w);
                b = iss ? (sx & msk) : elem(vs1 + r, e, w);
                d |= VLEN'(alu(op, a, b, w) & msk) << (e * w);
                if (idx >= vstart && idx < vl && (vm || v0[idx]))
                    en |= VLENB'((1 << sewb) - 1) << (e * sewb);
            end
            e_busy[acc + r]      = 1'b1;
            e_rd[acc + r]        = {5'(vs2 + r), 5'(vs1 + r)};
            e_wen[acc + 2 + r]   = en;
            e_waddr[acc + 2 + r] = 5'(vd + r);
            e_wdata[acc + 2 + r] = d;
        end
        e_busy[acc + nreg]     = 1'b1;
        e_busy[acc + nreg + 1] = 1'b1;
        e_done[acc + nreg + 1] = 1'b1;
        end_cyc = acc + nreg + 1;
    endtask

    task automatic abort_from(input int k);
        for (int c = k; c <= end_cyc + 4; c++) begin
            if (e_wen.exists(c))   e_wen.delete(c);
            if (e_waddr.exists(c)) e_waddr.delete(c);
            if (e_wdata.exists(c)) e_wdata.delete(c);
            if (e_rd.exists(c))    e_rd.delete(c);
            if (e_done.exists(c))  e_done.delete(c);
            if (e_err.exists(c))   e_err.delete(c);
            if (e_busy.exists(c))  e_busy.delete(c);
        end
        end_cyc = k - 1;
    endtask

    // Called at a negedge; returns at the following negedge, where cyc == acc (accept+1).
    task automatic issue(input int op, input int sew, input logic [2:0] lmul, input int vl,
                         input int vstart, input bit vm, input bit iss, input logic [31:0] scal,
                         input int vd, input int vs1, input int vs2, input logic [127:0] v0,
                         output int acc);
        int wt = 0;
        while (!in_ready && wt < 100) begin
            @(negedge clk);
            wt++;
        end
        if (!in_ready) begin
            checks++;
            fails++;
            $display("FAIL issue_timeout cyc=%0d got=in_ready_low want=in_ready_high", cyc);
        end
        op_i = 3'(op); sew_i = 2'(sew); lmul_i = lmul; vl_i = VLW'(vl); vstart_i = VLW'(vstart);
        vm_i = vm; iss_i = iss; scal_i = scal; vd_i = 5'(vd); vs1_i = 5'(vs1); vs2_i = 5'(vs2);
        v0_i = v0;
        in_valid = 1'b1;
        acc = cyc + 1;
        model(acc, op, sew, lmul, vl, vstart, vm, iss, scal, vd, vs1, vs2, v0);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", VLEN'(in_ready), VLEN'(!e_busy.exists(cyc)));
            chk("rd_en", VLEN'(rf_rd_en), VLEN'(e_rd.exists(cyc)));
            if (e_rd.exists(cyc)) chk("rd_addr", VLEN'({rd_addr_a, rd_addr_b}), VLEN'(e_rd[cyc]));
            chk("wr_en", VLEN'(rf_wr_en), e_wen.exists(cyc) ? VLEN'(e_wen[cyc]) : '0);
            if (e_wen.exists(cyc)) begin
                chk("wr_addr", VLEN'(rf_wr_addr), VLEN'(e_waddr[cyc]));
                chk("wr_data", rf_wr_data, e_wdata[cyc]);
            end
            chk("done", VLEN'(done), VLEN'(e_done.exists(cyc)));
            chk("err", VLEN'(err), VLEN'(e_err.exists(cyc)));
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        for (int i = 0; i < 32; i++) rf[i] = {$urandom, $urandom, $urandom, $urandom};
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", VLEN'(in_ready), VLEN'(1));
        chk("rst_rd_en", VLEN'(rf_rd_en), '0);
        chk("rst_wr_en", VLEN'(rf_wr_en), '0);
        chk("rst_wr_addr", VLEN'(rf_wr_addr), '0);
        chk("rst_wr_data", rf_wr_data, '0);
        chk("rst_done", VLEN'(done), '0);
        chk("rst_err", VLEN'(err), '0);
        chk_en = 1'b1;

        // SEW8 add: 0xFF + 0x02 wraps to 0x01 per byte
        rf[2] = {16{8'hFF}};
        rf[3] = {16{8'h02}};
        issue(0, 0, 3'b000, 16, 0, 1, 0, 0, 1, 3, 2, '0, acc);
        wait_cyc(acc + 2);
        chk("t1_wen", VLEN'(rf_wr_en), VLEN'(16'hFFFF));
        chk("t1_data", rf_wr_data, {16{8'h01}});
        chk("t1_done", VLEN'(done), VLEN'(1));

        // SEW32 LMUL4 sub, vl=10 -> 3 registers, tail on the third
        for (int i = 0; i < 4; i++) begin
            rf[8 + i]  = {4{32'd10}};
            rf[12 + i] = {4{32'd3}};
        end
        issue(1, 2, 3'b010, 10, 0, 1, 0, 0, 4, 12, 8, '0, acc);
        wait_cyc(acc + 2);
        chk("t2_addr0", VLEN'(rf_wr_addr), VLEN'(4));
        wait_cyc(acc + 4);
        chk("t2_wen2", VLEN'(rf_wr_en), VLEN'(16'h00FF));
        chk("t2_data2", rf_wr_data, {4{32'd7}});
        chk("t2_addr2", VLEN'(rf_wr_addr), VLEN'(6));
        chk("t2_done", VLEN'(done), VLEN'(1));

        // SEW16 masked xor with vstart=2
        issue(4, 1, 3'b001, 16, 2, 0, 0, 0, 20, 18, 16, 128'h5555, acc);
        wait_cyc(acc + 2);
        chk("t3_wen0", VLEN'(rf_wr_en), VLEN'(16'h3330));
        wait_cyc(acc + 3);
        chk("t3_wen1", VLEN'(rf_wr_en), VLEN'(16'h3333));

        // SEW64 scalar max: scalar sign-extends to -2^31
        rf[24] = '0;
        issue(7, 3, 3'b000, 2, 0, 1, 1, 32'h8000_0000, 26, 25, 24, '0, acc);
        wait_cyc(acc + 2);
        chk("t4_data", rf_wr_data, '0);
        chk("t4_wen", VLEN'(rf_wr_en), VLEN'(16'hFFFF));
        issue(6, 3, 3'b000, 2, 0, 1, 1, 32'h8000_0000, 26, 25, 24, '0, acc);
        wait_cyc(acc + 2);
        chk("t4_min", rf_wr_data, {2{64'hFFFF_FFFF_8000_0000}});

        // misaligned vd for LMUL4 -> err, then a legal op
        issue(0, 0, 3'b010, 16, 0, 1, 0, 0, 6, 12, 8, '0, acc);
        chk("t5_err", VLEN'(err), VLEN'(1));
        chk("t5_ready", VLEN'(in_ready), VLEN'(1));
        chk("t5_rd_en", VLEN'(rf_rd_en), '0);
        issue(6, 0, 3'b001, 20, 3, 0, 0, 0, 20, 26, 22, {$urandom, $urandom, $urandom, $urandom}, acc);

        // more directed patterns, issued back to back
        issue(0, 0, 3'b100, 8, 0, 1, 0, 0, 0, 0, 0, '0, acc);
        issue(6, 1, 3'b001, 12, 0, 1, 1, 32'hFFFF_8001, 2, 5, 4, '0, acc);
        issue(5, 1, 3'b001, 16, 0, 1, 0, 0, 28, 30, 24, '0, acc);
        issue(3, 2, 3'b000, 3, 1, 1, 0, 0, 9, 10, 11, '0, acc);
        issue(2, 2, 3'b011, 40, 0, 0, 0, 0, 8, 24, 16, {$urandom, $urandom, $urandom, $urandom}, acc);
        issue(0, 3, 3'b001, 3, 0, 1, 0, 0, 6, 2, 4, '0, acc);
        issue(1, 3, 3'b000, 2, 0, 1, 1, 32'h0000_0005, 7, 3, 9, '0, acc);
        issue(0, 0, 3'b000, 5, 5, 1, 0, 0, 1, 2, 3, '0, acc);
        chk("vstart_ge_vl_done", VLEN'(done), VLEN'(1));

        // reset during RUN after the second read
        issue(0, 0, 3'b011, 128, 0, 1, 0, 0, 0, 16, 8, '0, acc);
        @(negedge clk);
        rst = 1'b1;
        abort_from(acc + 2);
        @(negedge clk);
        chk("t6_wr_en", VLEN'(rf_wr_en), '0);
        chk("t6_done", VLEN'(done), '0);
        chk("t6_ready", VLEN'(in_ready), VLEN'(1));
        rst = 1'b0;
        issue(0, 0, 3'b000, 0, 0, 1, 0, 0, 1, 2, 3, '0, acc);
        chk("t6_vl0_done", VLEN'(done), VLEN'(1));
        chk("t6_vl0_rd", VLEN'(rf_rd_en), '0);

        wait_cyc(end_cyc + 3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/riscv_v_exe_seq.md
Name: riscv_v_exe_seq

Overview:
- Multi-cycle vector integer execute unit that runs one RVV arithmetic/logic instruction over a whole register group (LMUL = 1/2/4/8).
- Issues one register per cycle to the vector register file and computes per-element results for SEW 8/16/32/64.
- Applies vstart/vl/v0 masking as byte write-enables (mask-undisturbed, tail-undisturbed).
- Sits between vector decode/issue and the vector RF write port. Generalises the single-register execute stage to register groups, configurable VLEN and a start/done handshake.

Parameters:
- VLEN, 128, vector register width in bits; power of two, ≥64.
- MAX_LMUL, 8, largest supported group size; power of two.
- XLEN, 32, scalar operand width.
- VLENB, VLEN/8, derived; bytes per register.
- VLW, $clog2(VLENB*MAX_LMUL)+1, derived; width of vl/vstart.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  instruction issue valid
- in_ready  out  1  unit idle, can accept
- op  in  3  000 add, 001 sub (vs2−src1), 010 and, 011 or, 100 xor, 101 minu, 110 min, 111 max
- sew  in  2  00=8, 01=16, 10=32, 11=64
- lmul  in  3  vtype.vlmul encoding; 000..011 legal, others illegal
- vl  in  VLW  vector length in elements
- vstart  in  VLW  first active element
- vm  in  1  1 = unmasked
- is_scalar  in  1  src1 is scalar_data, not vs1
- scalar_data  in  XLEN  scalar operand, sign-extended or truncated to SEW
- vd_addr, vs1_addr, vs2_addr  in  5 each  group base registers
- v0_mask  in  VLENB*MAX_LMUL  v0 contents, bit i = element i
- rf_rd_addr_a, rf_rd_addr_b  out  5 each  RF read addresses (vs2+r, vs1+r)
- rf_rd_en  out  1  read request
- rf_rd_data_a, rf_rd_data_b  in  VLEN each  read data, valid exactly 1 cycle after rf_rd_en
- rf_wr_en  out  VLENB  byte write enables
- rf_wr_addr  out  5  vd+r
- rf_wr_data  out  VLEN  result
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle illegal-instruction pulse

Behaviour:
- Reset: state IDLE; in_ready=1; rf_rd_en=0; rf_wr_en=0; rf_wr_addr=0; rf_wr_data=0; done=0; err=0.
- Reset mid-operation aborts immediately. No write is issued in the following cycle.
- Accept on in_valid && in_ready. All inputs, including v0_mask, are captured on accept.
- in_ready=1 only in IDLE.
- Legality check on accept. err pulses next cycle, no reads or writes, state stays IDLE, if any of:
  - lmul ∉ {000..011}
  - LMUL > MAX_LMUL
  - any vector address not a multiple of LMUL (vs1 ignored when is_scalar)
- NREG = min(LMUL, ceil(vl·SEWB/VLENB)). If vl==0 or vstart≥vl: no accesses, done pulses next cycle.
- FSM:
  - IDLE → RUN on a legal accept.
  - RUN: rf_rd_en=1, addresses = base+r, r increments each cycle. After r=NREG−1 go to DRAIN.
  - DRAIN: 2 cycles, then IDLE.
- Pipeline:
  - read issued cycle k; data at k+1 (combinational ALU); registered write outputs at k+2.
  - First write appears 3 cycles after accept. done pulses in the same cycle as the last write.
  - Throughput: one register per cycle, no bubbles.
- Element index for register r, lane e: idx = r·(VLENB/SEWB)+e.
- Byte-enables for element idx are all 1 iff vstart ≤ idx < vl and (vm || v0_mask[idx]); otherwise 0 (undisturbed).
- Arithmetic:
  - wrap-around modulo 2^SEW; no carry between elements.
  - min/max are signed; minu is unsigned.
  - scalar_data is sign-extended when SEW > XLEN and truncated when smaller.
- rf_wr_data is the computed value in all lanes; disabled lanes are don't-care but must be deterministic.
- A new instruction may be accepted the cycle after returning to IDLE.

Test Plan:
- SEW=8, LMUL=1, vl=16, vm=1, add, vs2=bytes 0xFF, vs1=bytes 0x02 → one write at vd, data all 0x01, rf_wr_en=0xFFFF, done in the same cycle (accept+3).
- SEW=32, LMUL=4, vl=10, vstart=0, sub, vs2=10, vs1=3 → 3 writes to vd..vd+2 (NREG=3), each lane=7; third write rf_wr_en=0x00FF.
- SEW=16, LMUL=2, vm=0, v0_mask=0x5555, vstart=2, vl=16, xor → only even elements ≥2 enabled; first write rf_wr_en=0x3330.
- is_scalar, SEW=64, XLEN=32, scalar=0x8000_0000, max signed vs vs2=0 → result 0 in every lane (scalar is −2^31).
- LMUL=4 with vd_addr=6 → err pulse at accept+1, no rf_rd_en, in_ready stays 1; then a legal instruction completes normally.
- rst asserted in RUN after the second read → next cycle rf_wr_en=0, done=0, in_ready=1; vl=0 instruction → done at accept+1, no accesses.
